onoff_output_port: RTL and testbench

// - Transmit side of the per-VC on/off flow control driven by downstream input-port buffers.
// - Sits at each router output port, after switch traversal and before the link.
// - Holds one flit per VC, forwards only to VCs whose downstream buffer signals "on".
// - Picks one eligible VC per cycle, round-robin; one flit per cycle onto the link.

---
 rtl/onoff_output_port_if.sv | 30 +++
 rtl/onoff_output_port.sv | 115 +++++++++++
 tb/tb_onoff_output_port.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/onoff_output_port_if.sv
// rtl/onoff_output_port_if.sv - flit type and crossbar/link handshake bundle for onoff_output_port
package noc_params;
    typedef struct packed {
        logic [3:0]  vc_id;
        logic [31:0] payload;
    } flit_t;
endpackage

interface onoff_output_port_if #(
    parameter int VC_NUM = 2
);
    import noc_params::*;

    flit_t              data_i;
    logic               valid_i;
    logic [VC_NUM-1:0]  ready_o;
    logic [VC_NUM-1:0]  on_off_i;
    flit_t              data_o;
    logic               valid_o;

    modport slave (
        input  data_i, valid_i, on_off_i,
        output ready_o, data_o, valid_o
    );

    modport master (
        output data_i, valid_i, on_off_i,
        input  ready_o, data_o, valid_o
    );
endinterface

// File: rtl/onoff_output_port.sv
// rtl/onoff_output_port.sv - per-VC on/off gated output port, one held flit per VC, round-robin onto the link
// Optional stall counter port stall_cnt_o is enabled by defining ONOFF_STALL_CNT_EN.
module onoff_output_port
    import noc_params::*;
#(
    parameter int VC_NUM      = 2,
    parameter int STALL_CNT_W = 16
) (
    input  logic clk,
    input  logic rst,
    onoff_output_port_if.slave bus
`ifdef ONOFF_STALL_CNT_EN
    ,
    output logic [STALL_CNT_W-1:0] stall_cnt_o
`endif
);
    localparam int PTR_W = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;

    flit_t              hold_q [VC_NUM];
    logic [VC_NUM-1:0]  hold_valid_q, hold_valid_d;
    logic [VC_NUM-1:0]  on_off_q;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic               valid_q, valid_d;
    flit_t              data_q, data_d;

    logic [VC_NUM-1:0]  elig;
    logic [VC_NUM-1:0]  grant_oh;
    logic [VC_NUM-1:0]  acc_oh;
    logic               grant_vld;
    logic [PTR_W-1:0]   grant_idx;
    int                 cand;

    assign elig = hold_valid_q & on_off_q;

    // Round-robin: first eligible VC at or above rr_ptr, wrapping.
    always_comb begin
        grant_oh  = '0;
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = 0;
        for (int i = 0; i < VC_NUM; i++) begin
            cand = int'(rr_ptr_q) + i;
            if (cand >= VC_NUM) begin
                cand = cand - VC_NUM;
            end
            if (!grant_vld && elig[cand]) begin
                grant_vld      = 1'b1;
                grant_idx      = PTR_W'(cand);
                grant_oh[cand] = 1'b1;
            end
        end
    end

    assign bus.ready_o = ~hold_valid_q | grant_oh;

    // Out-of-range vc_id matches no VC, so such flits are dropped silently.
    always_comb begin
        acc_oh = '0;
        for (int v = 0; v < VC_NUM; v++) begin
            acc_oh[v] = bus.valid_i && (int'(bus.data_i.vc_id) == v) && bus.ready_o[v];
        end
    end

    always_comb begin
        hold_valid_d = (hold_valid_q & ~grant_oh) | acc_oh;
        rr_ptr_d     = rr_ptr_q;
        if (grant_vld) begin
            rr_ptr_d = (int'(grant_idx) == VC_NUM - 1) ? '0 : grant_idx + 1'b1;
        end
        valid_d = grant_vld;
        data_d  = grant_vld ? hold_q[grant_idx] : data_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_valid_q <= '0;
            on_off_q     <= '1;
            rr_ptr_q     <= '0;
            valid_q      <= 1'b0;
            data_q       <= '0;
        end else begin
            hold_valid_q <= hold_valid_d;
            on_off_q     <= bus.on_off_i;
            rr_ptr_q     <= rr_ptr_d;
            valid_q      <= valid_d;
            data_q       <= data_d;
            for (int v = 0; v < VC_NUM; v++) begin
                if (acc_oh[v]) begin
                    hold_q[v] <= bus.data_i;
                end
            end
        end
    end

    assign bus.valid_o = valid_q;
    assign bus.data_o  = data_q;

`ifdef ONOFF_STALL_CNT_EN
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic                   stall_any;

    assign stall_any   = |(hold_valid_q & ~on_off_q);
    assign stall_cnt_d = (stall_any && !(&stall_cnt_q)) ? stall_cnt_q + 1'b1 : stall_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif
endmodule

// File: tb/tb_onoff_output_port.sv
// tb/tb_onoff_output_port.sv - randomized bench for onoff_output_port against a slot-level reference model
module tb_onoff_output_port;
    import noc_params::*;

    localparam int VC_NUM      = 2;
    localparam int STALL_CNT_W = 3;
    localparam int STALL_MAX   = (1 << STALL_CNT_W) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    onoff_output_port_if #(.VC_NUM(VC_NUM)) bus ();

`ifdef ONOFF_STALL_CNT_EN
    logic [STALL_CNT_W-1:0] stall_cnt;
`endif

    onoff_output_port #(
        .VC_NUM      (VC_NUM),
        .STALL_CNT_W (STALL_CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus)
`ifdef ONOFF_STALL_CNT_EN
        ,
        .stall_cnt_o (stall_cnt)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    bit    m_full  [VC_NUM];
    flit_t m_slot  [VC_NUM];
    bit    m_on    [VC_NUM];
    int    m_next;
    bit    m_valid;
    flit_t m_data;
    int    m_stall;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int v = 0; v < VC_NUM; v++) begin
            m_full[v] = 1'b0;
            m_on[v]   = 1'b1;
        end
        m_next  = 0;
        m_valid = 1'b0;
        m_data  = '0;
        m_stall = 0;
    endtask

    // One clock: predict ready from the model, let the edge happen, then advance the model and compare.
    task automatic step();
        int win;
        bit stalled;
        logic [VC_NUM-1:0] exp_ready;
        win = -1;
        for (int k = 0; k < VC_NUM; k++) begin
            int v;
            v = (m_next + k) % VC_NUM;
            if (win < 0 && m_full[v] && m_on[v]) win = v;
        end
        for (int v = 0; v < VC_NUM; v++) exp_ready[v] = !m_full[v] || (win == v);
        chk("ready_o", 64'(bus.ready_o), 64'(exp_ready));
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            stalled = 1'b0;
            for (int v = 0; v < VC_NUM; v++) if (m_full[v] && !m_on[v]) stalled = 1'b1;
            if (stalled && m_stall < STALL_MAX) m_stall++;
            m_valid = (win >= 0);
            if (win >= 0) begin
                m_data      = m_slot[win];
                m_full[win] = 1'b0;
                m_next      = (win + 1) % VC_NUM;
            end
            if (bus.valid_i && int'(bus.data_i.vc_id) < VC_NUM && exp_ready[bus.data_i.vc_id]) begin
                m_slot[bus.data_i.vc_id] = bus.data_i;
                m_full[bus.data_i.vc_id] = 1'b1;
            end
            for (int v = 0; v < VC_NUM; v++) m_on[v] = bus.on_off_i[v];
        end
        #1;
        chk("valid_o", 64'(bus.valid_o), 64'(m_valid));
        chk("data_o", 64'(bus.data_o), 64'(m_data));
`ifdef ONOFF_STALL_CNT_EN
        chk("stall_cnt_o", 64'(stall_cnt), 64'(m_stall));
`endif
    endtask

    task automatic drive(input bit vld, input int vc, input logic [VC_NUM-1:0] oo);
        bus.valid_i         = vld;
        bus.data_i.vc_id    = 4'(vc);
        bus.data_i.payload  = $urandom;
        bus.on_off_i        = oo;
        step();
    endtask

    logic [31:0] saved;
    int          link_vc [$];
    int          vc1_after_drop;

    initial begin
        rst          = 1'b1;
        bus.valid_i  = 1'b0;
        bus.data_i   = '0;
        bus.on_off_i = '1;
        repeat (2) @(posedge clk);
        model_reset();
        #1;
        rst = 1'b0;
        chk("rst_ready", 64'(bus.ready_o), 64'({VC_NUM{1'b1}}));
        chk("rst_valid", 64'(bus.valid_o), 64'd0);

        // Pre-reset traffic, then reset held 2 cycles with valid_i high.
        repeat (6) drive(1'b1, $urandom_range(0, VC_NUM - 1), 2'b00);
        rst = 1'b1;
        repeat (2) begin
            drive(1'b1, 0, '1);
            chk("mid_rst_valid", 64'(bus.valid_o), 64'd0);
        end
        rst = 1'b0;
        drive(1'b0, 0, '1);
        chk("post_rst_valid", 64'(bus.valid_o), 64'd0);
        chk("post_rst_ready", 64'(bus.ready_o), 64'({VC_NUM{1'b1}}));

        // Single flit: accepted at one edge, on the link after the next.
        bus.data_i.payload = '0;
        bus.valid_i        = 1'b1;
        bus.data_i.vc_id   = 4'd0;
        bus.data_i.payload = 32'hA5A5_0001;
        bus.on_off_i       = '1;
        saved              = bus.data_i.payload;
        step();
        chk("single_lat0", 64'(bus.valid_o), 64'd0);
        drive(1'b0, 0, '1);
        chk("single_valid", 64'(bus.valid_o), 64'd1);
        chk("single_data", 64'(bus.data_o.payload), 64'(saved));
        drive(1'b0, 0, '1);
        chk("single_drop", 64'(bus.valid_o), 64'd0);

        // Round-robin: alternate VCs, expect alternating link order.
        link_vc.delete();
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, k % 2, '1);
            if (bus.valid_o) link_vc.push_back(int'(bus.data_o.vc_id));
        end
        repeat (3) begin
            drive(1'b0, 0, '1);
            if (bus.valid_o) link_vc.push_back(int'(bus.data_o.vc_id));
        end
        chk("rr_count", 64'(link_vc.size()), 64'd8);
        foreach (link_vc[i]) chk("rr_order", 64'(link_vc[i]), 64'(i % 2));

        // VC1 switched off mid-stream: at most one more VC1 flit.
        for (int k = 0; k < 6; k++) drive(1'b1, k % 2, '1);
        vc1_after_drop = 0;
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, k % 2, 2'b01);
            if (bus.valid_o && bus.data_o.vc_id == 4'd1) vc1_after_drop++;
        end
        chk("off_vc1_ready", 64'(bus.ready_o[1]), 64'd0);
        chk("off_vc1_limit", 64'(vc1_after_drop <= 1), 64'd1);
        repeat (3) drive(1'b0, 0, '1);

        // Refill: VC0 every cycle gives one flit per cycle.
        drive(1'b1, 0, '1);
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 0, '1);
            chk("refill_b2b", 64'(bus.valid_o), 64'd1);
        end
        repeat (2) drive(1'b0, 0, '1);

`ifdef ONOFF_STALL_CNT_EN
        rst = 1'b1;
        drive(1'b0, 0, '1);
        rst = 1'b0;
        drive(1'b1, 0, 2'b10);
        repeat (5) drive(1'b0, 0, 2'b10);
        chk("stall_five", 64'(stall_cnt), 64'd5);
        repeat (6) drive(1'b0, 0, 2'b10);
        chk("stall_sat", 64'(stall_cnt), 64'(STALL_MAX));
        repeat (2) drive(1'b0, 0, '1);
`endif

        // Random traffic, including out-of-range vc_id and random on/off patterns.
        for (int k = 0; k < 3000; k++) begin
            rst = ($urandom_range(0, 299) == 0);
            drive($urandom_range(0, 3) != 0, $urandom_range(0, VC_NUM),
                  ($urandom_range(0, 2) == 0) ? VC_NUM'($urandom) : {VC_NUM{1'b1}});
        end
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
